// File: rtl/hazard_bubble_ctrl.sv
// Control-hazard bubble generator: flushes the pipeline for a fixed number of
// cycles after a taken jump/branch or an eret/syscall. Optional macro: BUBBLE_STATS_EN.
module hazard_bubble_ctrl #(
   parameter int CNT_W       = 2,
   parameter int BR_BUBBLES  = 3,
   parameter int EXC_BUBBLES = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             jump,
   input  logic             jal,
   input  logic             jalr,
   input  logic             beq,
   input  logic             bne,
   input  logic             bgez,
   input  logic             bltz,
   input  logic             bgtz,
   input  logic             blez,
   input  logic             zero,
   input  logic             zbgez,
   input  logic             zbgtz,
   input  logic             eret,
   input  logic             syscall,
   output logic [CNT_W-1:0] bubble,
   output logic [CNT_W-1:0] bubble_exc,
   output logic             flush,
   output logic             redirect,
   output logic [1:0]       state_dbg
`ifdef BUBBLE_STATS_EN
   ,
   output logic [31:0]      br_bubble_total,
   output logic [31:0]      exc_bubble_total
`endif
);

   // Requests have no ready: a request is accepted on any non-stalled edge
   // where the FSM acts on it; acceptance is reported by redirect next cycle.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BR   = 2'd1,
      S_EXC  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] BR_N  = CNT_W'(BR_BUBBLES);
   localparam logic [CNT_W-1:0] EXC_N = CNT_W'(EXC_BUBBLES);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             redirect_nx;
   logic             taken, exc_req;

   assign taken = jump | jal | jalr
                | (beq  &  zero)  | (bne  & ~zero)
                | (bgez &  zbgez) | (bltz & ~zbgez)
                | (bgtz &  zbgtz) | (blez & ~zbgtz);
   assign exc_req = eret | syscall;

   assign state_dbg = state;

   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      redirect_nx = 1'b0;
      if (!stall) begin
         case (state)
            S_IDLE: begin
               if (exc_req) begin
                  state_nx    = S_EXC;
                  cnt_nx      = EXC_N;
                  redirect_nx = 1'b1;
               end else if (taken) begin
                  state_nx    = S_BR;
                  cnt_nx      = BR_N;
                  redirect_nx = 1'b1;
               end
            end
            S_BR, S_EXC: begin
               // Taken branches here are wrong-path and ignored; exceptions
               // preempt a branch flush or restart an exception flush.
               if (exc_req) begin
                  state_nx    = S_EXC;
                  cnt_nx      = EXC_N;
                  redirect_nx = 1'b1;
               end else if (cnt <= ONE) begin
                  state_nx = S_IDLE;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = cnt - ONE;
               end
            end
            default: begin
               state_nx = S_IDLE;
               cnt_nx   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         bubble     <= '0;
         bubble_exc <= '0;
         flush      <= 1'b0;
         redirect   <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         bubble     <= (state_nx == S_BR)  ? cnt_nx : '0;
         bubble_exc <= (state_nx == S_EXC) ? cnt_nx : '0;
         flush      <= (state_nx != S_IDLE);
         redirect   <= redirect_nx;
      end
   end

`ifdef BUBBLE_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         br_bubble_total  <= '0;
         exc_bubble_total <= '0;
      end else if (!stall) begin
         if (state == S_BR && br_bubble_total != 32'hFFFF_FFFF)
            br_bubble_total <= br_bubble_total + 32'd1;
         if (state == S_EXC && exc_bubble_total != 32'hFFFF_FFFF)
            exc_bubble_total <= exc_bubble_total + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_bubble_ctrl.sv
// Self-checking bench for hazard_bubble_ctrl: directed scenarios plus random
// stimulus against a flush-bookkeeping model. Honours BUBBLE_STATS_EN.
module tb_hazard_bubble_ctrl;

   localparam int CNT_W = 2;
   localparam int BR_N  = 3;
   localparam int EXC_N = 3;

   logic clk = 1'b0;
   logic rst_n, stall, jump, jal, jalr, beq, bne, bgez, bltz, bgtz, blez;
   logic zero, zbgez, zbgtz, eret, syscall;
   logic [CNT_W-1:0] bubble, bubble_exc;
   logic             flush, redirect;
   logic [1:0]       state_dbg;
`ifdef BUBBLE_STATS_EN
   logic [31:0] br_bubble_total, exc_bubble_total;
`endif

   int n_checks = 0;
   int n_errors = 0;
   logic [CNT_W-1:0] exp_q[$];

   // model: what is being flushed (0 none, 1 branch, 2 exception) and how many bubbles remain
   int          m_kind, m_left;
   bit          m_redir;
   longint      m_br_tot, m_exc_tot;

   always #5 clk = ~clk;

   hazard_bubble_ctrl #(.CNT_W(CNT_W), .BR_BUBBLES(BR_N), .EXC_BUBBLES(EXC_N)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall),
      .jump(jump), .jal(jal), .jalr(jalr),
      .beq(beq), .bne(bne), .bgez(bgez), .bltz(bltz), .bgtz(bgtz), .blez(blez),
      .zero(zero), .zbgez(zbgez), .zbgtz(zbgtz),
      .eret(eret), .syscall(syscall),
      .bubble(bubble), .bubble_exc(bubble_exc), .flush(flush), .redirect(redirect),
      .state_dbg(state_dbg)
`ifdef BUBBLE_STATS_EN
      , .br_bubble_total(br_bubble_total), .exc_bubble_total(exc_bubble_total)
`endif
   );

   task automatic clear_inputs();
      rst_n = 1'b1; stall = 1'b0;
      jump = 0; jal = 0; jalr = 0; beq = 0; bne = 0; bgez = 0; bltz = 0;
      bgtz = 0; blez = 0; zero = 0; zbgez = 0; zbgtz = 0; eret = 0; syscall = 0;
   endtask

   task automatic model_edge();
      bit tk, ex;
      tk = jump || jal || jalr || (beq && zero) || (bne && !zero) ||
           (bgez && zbgez) || (bltz && !zbgez) || (bgtz && zbgtz) || (blez && !zbgtz);
      ex = eret || syscall;
      if (!rst_n) begin
         m_kind = 0; m_left = 0; m_redir = 0; m_br_tot = 0; m_exc_tot = 0;
      end else if (stall) begin
         m_redir = 0;
      end else begin
         if (m_kind == 1 && m_br_tot  < 64'hFFFF_FFFF) m_br_tot++;
         if (m_kind == 2 && m_exc_tot < 64'hFFFF_FFFF) m_exc_tot++;
         m_redir = 0;
         if (ex) begin
            m_kind = 2; m_left = EXC_N; m_redir = 1;
         end else if (m_kind == 0 && tk) begin
            m_kind = 1; m_left = BR_N; m_redir = 1;
         end else if (m_kind != 0) begin
            m_left = m_left - 1;
            if (m_left == 0) m_kind = 0;
         end
      end
   endtask

   // one rising edge (model follows the same edge), returns at the falling edge
   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0; stall = 1'b1; jump = 1'b1; eret = 1'b1;
      tick();
      n_checks++;
      if ({bubble, bubble_exc, flush, redirect} !== {2'd0, 2'd0, 1'b0, 1'b0}) begin
         n_errors++;
         $display("FAIL reset: bubble=%0d bubble_exc=%0d flush=%b redirect=%b, required all 0",
                  bubble, bubble_exc, flush, redirect);
      end
`ifdef BUBBLE_STATS_EN
      n_checks++;
      if ({br_bubble_total, exc_bubble_total} !== 64'd0) begin
         n_errors++;
         $display("FAIL reset_stats: br=%0d exc=%0d, required 0", br_bubble_total, exc_bubble_total);
      end
`endif
      clear_inputs();
   endtask

   task automatic test_branch_taken();
      logic [CNT_W-1:0] e;
      exp_q.push_back(2'd3); exp_q.push_back(2'd2); exp_q.push_back(2'd1); exp_q.push_back(2'd0);
      beq = 1'b1; zero = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         clear_inputs();
         e = exp_q.pop_front();
         n_checks++;
         if ({bubble, bubble_exc, flush, redirect} !== {e, 2'd0, (i < 3), (i == 0)}) begin
            n_errors++;
            $display("FAIL beq_taken[%0d]: bubble=%0d bubble_exc=%0d flush=%b redirect=%b, required %0d/0/%b/%b",
                     i, bubble, bubble_exc, flush, redirect, e, (i < 3), (i == 0));
         end
      end
   endtask

   task automatic test_not_taken();
      bne = 1'b1; zero = 1'b1;
      tick();
      clear_inputs();
      n_checks++;
      if ({bubble, flush, redirect} !== {2'd0, 1'b0, 1'b0}) begin
         n_errors++;
         $display("FAIL bne_not_taken: bubble=%0d flush=%b redirect=%b, required 0/0/0", bubble, flush, redirect);
      end
      bltz = 1'b1; zbgez = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         clear_inputs();
         n_checks++;
         if (bubble !== 2'(3 - i)) begin
            n_errors++;
            $display("FAIL bltz_taken[%0d]: bubble=%0d, required %0d", i, bubble, 3 - i);
         end
      end
   endtask

   task automatic test_preempt();
      jal = 1'b1;
      tick();
      clear_inputs();
      tick();
      n_checks++;
      if (bubble !== 2'd2) begin
         n_errors++;
         $display("FAIL preempt_setup: bubble=%0d, required 2", bubble);
      end
      syscall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         clear_inputs();
         n_checks++;
         if ({bubble, bubble_exc, redirect} !== {2'd0, 2'(3 - i), (i == 0)}) begin
            n_errors++;
            $display("FAIL preempt[%0d]: bubble=%0d bubble_exc=%0d redirect=%b, required 0/%0d/%b",
                     i, bubble, bubble_exc, redirect, 3 - i, (i == 0));
         end
      end
   endtask

   task automatic test_stall();
      int exp_b[5] = '{2, 2, 2, 1, 0};
      jump = 1'b1;
      tick();
      clear_inputs();
      for (int i = 0; i < 5; i++) begin
         stall = (i == 1 || i == 2);
         tick();
         clear_inputs();
         n_checks++;
         if ({bubble, redirect, flush} !== {2'(exp_b[i]), 1'b0, (exp_b[i] != 0)}) begin
            n_errors++;
            $display("FAIL stall_hold[%0d]: bubble=%0d redirect=%b flush=%b, required %0d/0/%b",
                     i, bubble, redirect, flush, exp_b[i], (exp_b[i] != 0));
         end
      end
   endtask

   task automatic test_priority();
      eret = 1'b1; jump = 1'b1;
      tick();
      clear_inputs();
      n_checks++;
      if ({bubble, bubble_exc, flush} !== {2'd0, 2'd3, 1'b1}) begin
         n_errors++;
         $display("FAIL eret_over_jump: bubble=%0d bubble_exc=%0d flush=%b, required 0/3/1",
                  bubble, bubble_exc, flush);
      end
      for (int i = 0; i < 3; i++) tick();
   endtask

   task automatic test_reset_mid();
      eret = 1'b1;
      tick();
      clear_inputs();
      tick();
      n_checks++;
      if (bubble_exc !== 2'd2) begin
         n_errors++;
         $display("FAIL reset_mid_setup: bubble_exc=%0d, required 2", bubble_exc);
      end
      rst_n = 1'b0; stall = 1'b1; syscall = 1'b1;
      tick();
      clear_inputs();
      n_checks++;
      if ({bubble, bubble_exc, flush, redirect} !== 6'd0) begin
         n_errors++;
         $display("FAIL reset_mid: bubble=%0d bubble_exc=%0d flush=%b redirect=%b, required all 0",
                  bubble, bubble_exc, flush, redirect);
      end
   endtask

`ifdef BUBBLE_STATS_EN
   task automatic test_stats();
      rst_n = 1'b0;
      tick();
      clear_inputs();
      beq = 1'b1; zero = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         clear_inputs();
      end
      n_checks++;
      if ({br_bubble_total, exc_bubble_total} !== {32'd3, 32'd0}) begin
         n_errors++;
         $display("FAIL stats_branch: br=%0d exc=%0d, required 3/0", br_bubble_total, exc_bubble_total);
      end
   endtask
`endif

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rst_n   = ($urandom_range(0, 49) != 0);
         stall   = ($urandom_range(0, 3) == 0);
         jump    = ($urandom_range(0, 15) == 0);
         jal     = ($urandom_range(0, 15) == 0);
         jalr    = ($urandom_range(0, 15) == 0);
         beq     = ($urandom_range(0, 7) == 0);
         bne     = ($urandom_range(0, 7) == 0);
         bgez    = ($urandom_range(0, 7) == 0);
         bltz    = ($urandom_range(0, 7) == 0);
         bgtz    = ($urandom_range(0, 7) == 0);
         blez    = ($urandom_range(0, 7) == 0);
         zero    = 1'($urandom);
         zbgez   = 1'($urandom);
         zbgtz   = 1'($urandom);
         eret    = ($urandom_range(0, 19) == 0);
         syscall = ($urandom_range(0, 19) == 0);
         tick();
         n_checks++;
         if ({bubble, bubble_exc, flush, redirect} !==
             {2'((m_kind == 1) ? m_left : 0), 2'((m_kind == 2) ? m_left : 0), (m_kind != 0), m_redir}) begin
            n_errors++;
            $display("FAIL random[%0d]: bubble=%0d bubble_exc=%0d flush=%b redirect=%b, required kind=%0d left=%0d redirect=%b",
                     i, bubble, bubble_exc, flush, redirect, m_kind, m_left, m_redir);
         end
`ifdef BUBBLE_STATS_EN
         n_checks++;
         if (br_bubble_total !== 32'(m_br_tot) || exc_bubble_total !== 32'(m_exc_tot)) begin
            n_errors++;
            $display("FAIL random_stats[%0d]: br=%0d exc=%0d, required %0d/%0d",
                     i, br_bubble_total, exc_bubble_total, m_br_tot, m_exc_tot);
         end
`endif
      end
      clear_inputs();
   endtask

   initial begin
      m_kind = 0; m_left = 0; m_redir = 0; m_br_tot = 0; m_exc_tot = 0;
      clear_inputs();
      @(negedge clk);
      test_reset();
      test_branch_taken();
      test_not_taken();
      test_preempt();
      test_stall();
      test_priority();
      test_reset_mid();
`ifdef BUBBLE_STATS_EN
      test_stats();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/hazard_bubble_ctrl.md
HAZARD_BUBBLE_CTRL -- requirements
Module: hazard_bubble_ctrl

Interface
REQ-001 Parameter CNT_W, default 2: bubble counter width in bits.
REQ-002 Parameter BR_BUBBLES, default 3: bubbles per taken jump/branch; legal range 1..2^CNT_W-1.
REQ-003 Parameter EXC_BUBBLES, default 3: bubbles per eret/syscall; legal range 1..2^CNT_W-1.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 stall  in  1  pipeline stall; freezes the block while high.
REQ-007 jump, jal, jalr  in  1 each  unconditional control transfer.
REQ-008 beq, bne, bgez, bltz, bgtz, blez  in  1 each  conditional branch decode.
REQ-009 zero, zbgez, zbgtz  in  1 each  ALU flags: equal, rs>=0, rs>0.
REQ-010 eret, syscall  in  1 each  exception entry/return request.
REQ-011 bubble  out  CNT_W  remaining branch bubbles; 0 outside BR state.
REQ-012 bubble_exc  out  CNT_W  remaining exception bubbles; 0 outside EXC state.
REQ-013 flush  out  1  high whenever state is not IDLE.
REQ-014 redirect  out  1  one-cycle pulse in the cycle after a request is accepted.

Function
REQ-015 taken = jump|jal|jalr|(beq&zero)|(bne&~zero)|(bgez&zbgez)|(bltz&~zbgez)|(bgtz&zbgtz)|(blez&~zbgtz).
REQ-016 exc_req = eret|syscall.
REQ-017 The block SHALL implement a 3-state FSM: IDLE, BR, EXC, with a single counter cnt of CNT_W bits.
REQ-018 IDLE, stall=0: exc_req -> EXC, cnt<=EXC_BUBBLES; else taken -> BR, cnt<=BR_BUBBLES; else stay.
REQ-019 BR/EXC, stall=0, no preemption: cnt<=cnt-1; when cnt==1 the next state is IDLE with cnt=0.
REQ-020 taken while in BR or EXC is ignored (wrong-path instruction).
REQ-021 exc_req in BR, stall=0: preempts; next state EXC, cnt<=EXC_BUBBLES.
REQ-022 exc_req in EXC, stall=0: restarts; cnt<=EXC_BUBBLES.
REQ-023 stall=1: state, cnt and all requests are held/ignored; redirect is 0 during stall.
REQ-024 Latency: a request sampled at edge k yields flush=1 and count=N from edge k until N non-stalled edges later.
REQ-025 Outputs are registered; bubble=cnt in BR, bubble_exc=cnt in EXC, otherwise 0.
REQ-026 cnt never wraps; decrement from 0 is impossible by construction.

Reset
REQ-027 rst_n=0 at a rising edge: state=IDLE, cnt=0, bubble=0, bubble_exc=0, flush=0, redirect=0, statistics counters=0.
REQ-028 Reset has priority over stall and all requests, including mid-flush.

Configuration
REQ-029 With BUBBLE_STATS_EN defined: add outputs br_bubble_total and exc_bubble_total (32-bit each), each incremented per non-stalled cycle spent in BR/EXC respectively, saturating at 32'hFFFF_FFFF.
REQ-030 Without BUBBLE_STATS_EN: those ports and counters do not exist; all other behaviour identical.

Verification
REQ-031 Reset, then beq=1, zero=1 for one cycle -> bubble 3,2,1,0 on successive edges, flush high 3 cycles, redirect pulse 1 cycle.
REQ-032 bne=1, zero=1 -> no bubble, flush=0, redirect=0; bltz=1, zbgez=0 -> bubble 3,2,1.
REQ-033 jal accepted, syscall when bubble=2 -> bubble=0, bubble_exc=3,2,1, second redirect pulse.
REQ-034 jump accepted, stall=1 for 2 cycles at bubble=2 -> bubble holds 2 for 2 cycles then 1,0.
REQ-035 eret and jump same cycle in IDLE -> EXC wins, bubble_exc=3, bubble=0.
REQ-036 rst_n=0 while bubble_exc=2 -> next edge all outputs 0; with BUBBLE_STATS_EN, three-bubble branch -> br_bubble_total=3.
